// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Memory-side responder for the data cache's miss / write-through traffic.
// A request (load miss, store, or both) is accepted in one edge. Any store
// word is committed to the backing array at that same edge. After LATENCY
// cycles, the enclosing 256-bit line(s) are returned with a one-cycle
// new_mem strobe.
//
// Parameters:
//   DEPTH_WORDS - backing array size in 32-bit words (power of two, multiple of 8)
//   LATENCY     - cycles from acceptance to new_mem (>= 1)
//
// Ports:
//   clk, rst           - clock, asynchronous active-high reset (array not cleared)
//   ld_req, ld_addr    - load-miss request and byte address
//   st_req, st_addr    - store request and byte address
//   st_data, st_we     - store word and write enable (st_we=0: line read only)
//   ld_data_mem        - line holding the captured ld_addr
//   str_data_mem       - line holding the captured st_addr
//   new_mem            - one-cycle strobe, both data buses valid while high
//   busy               - transaction in flight
//   ovf                - sticky: a request arrived while busy and was dropped

module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_req,
  input  logic [31:0]  ld_addr,
  input  logic         st_req,
  input  logic [31:0]  st_addr,
  input  logic [31:0]  st_data,
  input  logic         st_we,
  output logic [255:0] ld_data_mem,
  output logic [255:0] str_data_mem,
  output logic         new_mem,
  output logic         busy,
  output logic         ovf
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // RESP is the cycle in which new_mem is high. It is also an acceptance
  // cycle, so the next request can be taken at T+LATENCY+1.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ld_pend_q, ld_pend_d;
  logic            st_pend_q, st_pend_d;
  logic [AW-4:0]   ld_line_q, ld_line_d;
  logic [AW-4:0]   st_line_q, st_line_d;
  logic [255:0]    ld_data_q, ld_data_d;
  logic [255:0]    str_data_q, str_data_d;
  logic            new_mem_q, new_mem_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;

  logic [31:0]     mem_array [DEPTH_WORDS];
  logic [255:0]    ld_line_rd;
  logic [255:0]    st_line_rd;
  logic            req;
  logic            accept;
  logic            mem_we;
  logic [AW-1:0]   st_widx;

  // Address bits above the array size wrap away.
  // Byte-offset bits are never used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_addr[31:AW+2], ld_addr[4:0],
                              st_addr[31:AW+2], st_addr[1:0]};

  assign req     = ld_req | st_req;
  assign accept  = req && (state_q != WAIT);
  assign mem_we  = accept && st_req && st_we && !rst;
  assign st_widx = st_addr[AW+1:2];

  // Store commit happens at the acceptance edge.
  // The response read later therefore sees the post-store image.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_array[st_widx] <= st_data;
    end
  end

  // Assemble both candidate response lines from the array.
  // Line word k occupies bits [32k+31:32k].
  always_comb begin
    ld_line_rd = '0;
    st_line_rd = '0;
    for (int k = 0; k < 8; k++) begin
      ld_line_rd[32*k +: 32] = mem_array[{ld_line_q, 3'(k)}];
      st_line_rd[32*k +: 32] = mem_array[{st_line_q, 3'(k)}];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_pend_d  = ld_pend_q;
    st_pend_d  = st_pend_q;
    ld_line_d  = ld_line_q;
    st_line_d  = st_line_q;
    ld_data_d  = ld_data_q;
    str_data_d = str_data_q;
    new_mem_d  = 1'b0;
    busy_d     = busy_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (accept) begin
          ld_pend_d = ld_req;
          st_pend_d = st_req;
          ld_line_d = ld_addr[AW+1:5];
          st_line_d = st_addr[AW+1:5];
          cnt_d     = CW'(LATENCY - 1);
          state_d   = WAIT;
          busy_d    = 1'b1;
        end
      end
      WAIT: begin
        if (req) begin
          ovf_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d   = RESP;
          new_mem_d = 1'b1;
          if (ld_pend_q) begin
            ld_data_d = ld_line_rd;
          end
          if (st_pend_q) begin
            str_data_d = st_line_rd;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ld_pend_q  <= 1'b0;
      st_pend_q  <= 1'b0;
      ld_line_q  <= '0;
      st_line_q  <= '0;
      ld_data_q  <= '0;
      str_data_q <= '0;
      new_mem_q  <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_pend_q  <= ld_pend_d;
      st_pend_q  <= st_pend_d;
      ld_line_q  <= ld_line_d;
      st_line_q  <= st_line_d;
      ld_data_q  <= ld_data_d;
      str_data_q <= str_data_d;
      new_mem_q  <= new_mem_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ld_data_mem  = ld_data_q;
  assign str_data_mem = str_data_q;
  assign new_mem      = new_mem_q;
  assign busy         = busy_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//
// Directed bench for data_mem_responder (DEPTH_WORDS=1024, LATENCY=4).
// A small word-array model mirrors every backdoor preload and every
// committed store. Expected lines are built from that model.

module tb_data_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld_req;
  logic [31:0]  ld_addr;
  logic         st_req;
  logic [31:0]  st_addr;
  logic [31:0]  st_data;
  logic         st_we;
  logic [255:0] ld_data_mem;
  logic [255:0] str_data_mem;
  logic         new_mem;
  logic         busy;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [1024];

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ld_req(ld_req),
    .ld_addr(ld_addr),
    .st_req(st_req),
    .st_addr(st_addr),
    .st_data(st_data),
    .st_we(st_we),
    .ld_data_mem(ld_data_mem),
    .str_data_mem(str_data_mem),
    .new_mem(new_mem),
    .busy(busy),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    dut.mem_array[idx] = v;
    model[idx] = v;
  endtask

  function automatic logic [255:0] model_line(input logic [31:0] addr);
    logic [255:0] r;
    int base;
    base = int'(addr[11:5]) * 8;
    r = '0;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = model[base + k];
    return r;
  endfunction

  task automatic clear_inputs();
    ld_req  = 1'b0;
    ld_addr = '0;
    st_req  = 1'b0;
    st_addr = '0;
    st_data = '0;
    st_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    checks++; if (new_mem !== 1'b0) begin errors++; $display("[TB] FAIL reset_new_mem: got %b expected 0", new_mem); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (ld_data_mem !== 256'h0) begin errors++; $display("[TB] FAIL reset_ld_data: got %h expected 0", ld_data_mem); end
    checks++; if (str_data_mem !== 256'h0) begin errors++; $display("[TB] FAIL reset_str_data: got %h expected 0", str_data_mem); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load();
    logic [255:0] exp;
    for (int k = 16; k < 24; k++) preload(k, (k == 16) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(k)));
    exp = model_line(32'h44);
    @(negedge clk);
    ld_req = 1'b1; ld_addr = 32'h44;
    tick();
    ld_req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL load_busy_accept: got %b expected 1", busy); end
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++; if (new_mem !== (c == 4)) begin errors++; $display("[TB] FAIL load_new_mem_c%0d: got %b expected %b", c, new_mem, (c == 4)); end
      if (c == 4) begin
        checks++; if (ld_data_mem !== exp) begin errors++; $display("[TB] FAIL load_line: got %h expected %h", ld_data_mem, exp); end
        checks++; if (ld_data_mem[31:0] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL load_word0: got %h expected deadbeef", ld_data_mem[31:0]); end
        checks++; if (str_data_mem !== 256'h0) begin errors++; $display("[TB] FAIL load_str_untouched: got %h expected 0", str_data_mem); end
      end
      if (c == 5) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL load_busy_release: got %b expected 0", busy); end
        checks++; if (ld_data_mem !== exp) begin errors++; $display("[TB] FAIL load_line_hold: got %h expected %h", ld_data_mem, exp); end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [255:0] exp;
    int nm;
    @(negedge clk);
    ld_req = 1'b1; ld_addr = 32'h40;
    st_req = 1'b1; st_we = 1'b1; st_addr = 32'h48; st_data = 32'h12345678;
    model[18] = 32'h12345678;
    exp = model_line(32'h40);
    tick();
    clear_inputs();
    checks++; if (dut.mem_array[18] !== 32'h12345678) begin errors++; $display("[TB] FAIL sim_array_write: got %h expected 12345678", dut.mem_array[18]); end
    nm = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (new_mem === 1'b1) nm++;
      if (c == 4) begin
        checks++; if (new_mem !== 1'b1) begin errors++; $display("[TB] FAIL sim_new_mem_t4: got %b expected 1", new_mem); end
        checks++; if (ld_data_mem !== exp) begin errors++; $display("[TB] FAIL sim_ld_line: got %h expected %h", ld_data_mem, exp); end
        checks++; if (str_data_mem !== exp) begin errors++; $display("[TB] FAIL sim_st_line: got %h expected %h", str_data_mem, exp); end
        checks++; if (ld_data_mem[95:64] !== 32'h12345678) begin errors++; $display("[TB] FAIL sim_ld_word2: got %h expected 12345678", ld_data_mem[95:64]); end
      end
    end
    checks++; if (nm != 1) begin errors++; $display("[TB] FAIL sim_single_strobe: got %0d strobes expected 1", nm); end
  endtask

  task automatic test_store_readonly();
    logic [255:0] exp_st;
    logic [255:0] exp_ld;
    for (int k = 32; k < 40; k++) preload(k, 32'hA000_0000 + 32'(k));
    exp_st = model_line(32'h80);
    exp_ld = model_line(32'h40);
    @(negedge clk);
    st_req = 1'b1; st_we = 1'b0; st_addr = 32'h80; st_data = 32'hFFFFFFFF;
    tick();
    clear_inputs();
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 4) begin
        checks++; if (str_data_mem !== exp_st) begin errors++; $display("[TB] FAIL ro_st_line: got %h expected %h", str_data_mem, exp_st); end
        checks++; if (ld_data_mem !== exp_ld) begin errors++; $display("[TB] FAIL ro_ld_hold: got %h expected %h", ld_data_mem, exp_ld); end
      end
    end
    checks++; if (dut.mem_array[32] !== 32'hA000_0020) begin errors++; $display("[TB] FAIL ro_array_unchanged: got %h expected a0000020", dut.mem_array[32]); end
  endtask

  task automatic test_overflow();
    logic [255:0] line40;
    logic [255:0] line80;
    int nm;
    line40 = model_line(32'h40);
    line80 = model_line(32'h80);
    @(negedge clk);
    ld_req = 1'b1; ld_addr = 32'h40;
    tick();
    nm = 0;
    for (int c = 1; c <= 10; c++) begin
      ld_req  = (c == 2) || (c == 5);
      ld_addr = 32'h80;
      tick();
      if (c <= 8 && new_mem === 1'b1) nm++;
      if (c == 1) begin
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear_before: got %b expected 0", ovf); end
      end
      if (c == 2) begin
        checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", ovf); end
      end
      if (c == 4) begin
        checks++; if (ld_data_mem !== line40) begin errors++; $display("[TB] FAIL ovf_first_resp: got %h expected %h", ld_data_mem, line40); end
      end
      if (c == 5) begin
        checks++; if (busy !== 1'b1 || new_mem !== 1'b0) begin errors++; $display("[TB] FAIL ovf_reaccept: got busy=%b new_mem=%b expected busy=1 new_mem=0", busy, new_mem); end
      end
      if (c == 9) begin
        checks++; if (new_mem !== 1'b1) begin errors++; $display("[TB] FAIL ovf_second_strobe: got %b expected 1", new_mem); end
        checks++; if (ld_data_mem !== line80) begin errors++; $display("[TB] FAIL ovf_second_resp: got %h expected %h", ld_data_mem, line80); end
      end
      if (c == 10) begin
        checks++; if (ovf !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL ovf_sticky_idle: got ovf=%b busy=%b expected ovf=1 busy=0", ovf, busy); end
      end
    end
    checks++; if (nm != 1) begin errors++; $display("[TB] FAIL ovf_strobe_count: got %0d strobes expected 1", nm); end
  endtask

  task automatic test_reset_mid();
    int nm;
    @(negedge clk);
    st_req = 1'b1; st_we = 1'b1; st_addr = 32'h100; st_data = 32'hCAFEF00D;
    model[64] = 32'hCAFEF00D;
    tick();
    clear_inputs();
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || new_mem !== 1'b0 || ovf !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ctrl: got busy=%b new_mem=%b ovf=%b expected 0 0 0", busy, new_mem, ovf); end
    checks++; if (ld_data_mem !== 256'h0 || str_data_mem !== 256'h0) begin errors++; $display("[TB] FAIL rstmid_data: got ld=%h st=%h expected 0", ld_data_mem, str_data_mem); end
    @(negedge clk);
    rst = 1'b0;
    nm = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (new_mem === 1'b1) nm++;
    end
    checks++; if (nm != 0) begin errors++; $display("[TB] FAIL rstmid_no_strobe: got %0d strobes expected 0", nm); end
    checks++; if (dut.mem_array[64] !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL rstmid_store_kept: got %h expected cafef00d", dut.mem_array[64]); end
  endtask

  task automatic test_wrap();
    logic [255:0] exp;
    for (int k = 0; k < 8; k++) preload(k, 32'hB000_0000 + 32'(k));
    exp = model_line(32'h0000_1000);
    @(negedge clk);
    ld_req = 1'b1; ld_addr = 32'h0000_1000;
    tick();
    clear_inputs();
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 4) begin
        checks++; if (ld_data_mem !== exp) begin errors++; $display("[TB] FAIL wrap_line: got %h expected %h", ld_data_mem, exp); end
        checks++; if (ld_data_mem[31:0] !== 32'hB000_0000) begin errors++; $display("[TB] FAIL wrap_word0: got %h expected b0000000", ld_data_mem[31:0]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = '0;
    test_reset();
    test_load();
    test_simultaneous();
    test_store_readonly();
    test_overflow();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
